// File: rtl/alu_seq_8_pkg.sv
// Shared opcode constants and FSM state encoding for the alu_seq_8 execution stage.
package alu_pkg;

   localparam logic [7:0] OP_ADD  = 8'h00;
   localparam logic [7:0] OP_SUB  = 8'h01;
   localparam logic [7:0] OP_AND  = 8'h02;
   localparam logic [7:0] OP_OR   = 8'h03;
   localparam logic [7:0] OP_XOR  = 8'h04;
   localparam logic [7:0] OP_MUL  = 8'h05;
   localparam logic [7:0] OP_DIV  = 8'h06;
   localparam logic [7:0] OP_MOD  = 8'h07;
   localparam logic [7:0] OP_SHL  = 8'h08;
   localparam logic [7:0] OP_SHR  = 8'h09;
   localparam logic [7:0] OP_LAST = OP_SHR;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ITER = 2'd2
   } state_e;

   function automatic logic is_iter_op(input logic [7:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_seq_8_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per clock.
module seq_muldiv_8 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               is_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] prod_o,
   output logic [WIDTH-1:0]   rem_o,
   output logic               done_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // hi holds the partial product (mul) or partial remainder (div); lo holds multiplier/quotient
   logic [WIDTH:0]   hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] m_q;
   logic             div_q;
   logic             act_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl;

   always_comb begin
      sum  = '0;
      shl  = '0;
      hi_d = hi_q;
      lo_d = lo_q;
      if (div_q) begin
         shl = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
         if (shl >= {1'b0, m_q}) begin
            hi_d = shl - {1'b0, m_q};
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = shl;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         sum  = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, m_q} : '0);
         hi_d = {1'b0, sum[WIDTH:1]};
         lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // The final step's values go straight out so the caller can register them on that same edge
   assign prod_o = {hi_d[WIDTH-1:0], lo_d};
   assign rem_o  = hi_d[WIDTH-1:0];
   assign done_o = act_q && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         div_q <= 1'b0;
         act_q <= 1'b0;
         cnt_q <= '0;
      end else if (start_i) begin
         hi_q  <= '0;
         lo_q  <= is_div_i ? a_i : b_i;
         m_q   <= is_div_i ? b_i : a_i;
         div_q <= is_div_i;
         act_q <= 1'b1;
         cnt_q <= '0;
      end else if (act_q) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == LAST) begin
            act_q <= 1'b0;
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_8.sv
// Execution stage: single-cycle logic ops plus iterative mul/div, registered result and flags.
module alu_seq_8
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   num_1,
   input  logic [WIDTH-1:0]   num_2,
   input  logic [7:0]         op_code,
   input  logic               i_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               flag_zero,
   output logic               flag_carry,
   output logic               flag_err,
   output logic               busy,
   output logic               overrun,
   output logic               o_ready
);

   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e             state_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [7:0]         op_q;
   logic [2*WIDTH-1:0] result_q;
   logic               zero_q, carry_q, err_q, overrun_q, oready_q;

   logic               accept, iter_go, md_start, md_done;
   logic [2*WIDTH-1:0] md_prod, iter_res, calc_res;
   logic [WIDTH-1:0]   md_rem;
   logic [WIDTH:0]     add_w;
   logic               calc_carry, calc_err;

   assign accept   = (state_q == IDLE) && i_ready;
   assign iter_go  = is_iter_op(op_code) && (num_2 != '0);
   assign md_start = accept && iter_go;

   seq_muldiv_8 #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (reset),
      .start_i  (md_start),
      .is_div_i (op_code != OP_MUL),
      .a_i      (num_1),
      .b_i      (num_2),
      .prod_o   (md_prod),
      .rem_o    (md_rem),
      .done_o   (md_done)
   );

   always_comb begin
      iter_res = {{WIDTH{1'b0}}, md_rem};
      if (op_q == OP_MUL)      iter_res = md_prod;
      else if (op_q == OP_DIV) iter_res = {{WIDTH{1'b0}}, md_prod[WIDTH-1:0]};
   end

   // MUL/DIV/MOD only reach CALC with a zero divisor/multiplier, so their result is 0 here
   always_comb begin
      calc_res   = '0;
      calc_carry = 1'b0;
      calc_err   = 1'b0;
      add_w      = {1'b0, a_q} + {1'b0, b_q};
      if (op_q > OP_LAST) begin
         calc_err = 1'b1;
      end else begin
         case (op_q)
            OP_ADD: begin
               calc_res   = {{(WIDTH-1){1'b0}}, add_w};
               calc_carry = add_w[WIDTH];
            end
            OP_SUB: begin
               calc_res   = {{WIDTH{1'b0}}, a_q - b_q};
               calc_carry = (a_q < b_q);
            end
            OP_AND:         calc_res = {{WIDTH{1'b0}}, a_q & b_q};
            OP_OR:          calc_res = {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR:         calc_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_DIV, OP_MOD: calc_err = 1'b1;
            OP_SHL:         calc_res = {{WIDTH{1'b0}}, a_q} << b_q[SW-1:0];
            OP_SHR:         calc_res = {{WIDTH{1'b0}}, a_q >> b_q[SW-1:0]};
            default:        calc_res = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
         oready_q  <= 1'b0;
      end else begin
         oready_q <= 1'b0;
         if (i_ready && (state_q != IDLE)) overrun_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (i_ready) begin
                  a_q     <= num_1;
                  b_q     <= num_2;
                  op_q    <= op_code;
                  state_q <= iter_go ? ITER : CALC;
               end
            end
            CALC: begin
               result_q <= calc_res;
               zero_q   <= (calc_res == '0);
               carry_q  <= calc_carry;
               err_q    <= calc_err;
               oready_q <= 1'b1;
               state_q  <= IDLE;
            end
            ITER: begin
               if (md_done) begin
                  result_q <= iter_res;
                  zero_q   <= (iter_res == '0);
                  carry_q  <= 1'b0;
                  err_q    <= 1'b0;
                  oready_q <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result     = result_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_err   = err_q;
   assign busy       = (state_q != IDLE);
   assign overrun    = overrun_q;
   assign o_ready    = oready_q;

endmodule

// File: tb/tb_alu_seq_8.sv
// Self-checking bench for alu_seq_8: directed plan vectors, random ops against a model, overrun and reset abort.
module tb_alu_seq_8;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  num_1, num_2, op_code;
   logic        i_ready;
   logic [15:0] result;
   logic        flag_zero, flag_carry, flag_err, busy, overrun, o_ready;

   int checks = 0;
   int errors = 0;

   alu_seq_8 #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .num_1      (num_1),
      .num_2      (num_2),
      .op_code    (op_code),
      .i_ready    (i_ready),
      .result     (result),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .flag_err   (flag_err),
      .busy       (busy),
      .overrun    (overrun),
      .o_ready    (o_ready)
   );

   always #5 clk = ~clk;

   // Reference: results straight from the arithmetic definition of each opcode
   function automatic void model(input int a, input int b, input int op,
                                 output int res, output bit c, output bit e, output int lat);
      res = 0; c = 1'b0; e = 1'b0; lat = 1;
      case (op)
         0: begin res = a + b; c = (res > 255); end
         1: begin res = (a - b) & 255; c = (a < b); end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: begin res = a * b; if (b != 0) lat = 8; end
         6: if (b == 0) e = 1'b1; else begin res = a / b; lat = 8; end
         7: if (b == 0) e = 1'b1; else begin res = a % b; lat = 8; end
         8: res = (a << (b % 8)) & 65535;
         9: res = a >> (b % 8);
         default: e = 1'b1;
      endcase
   endfunction

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        output logic [15:0] r, output logic z, output logic c, output logic e,
                        output int lat, output int bcnt);
      @(negedge clk);
      num_1 = a; num_2 = b; op_code = op; i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      lat = 0; bcnt = 0;
      while (!o_ready && lat < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      r = result; z = flag_zero; c = flag_carry; e = flag_err;
   endtask

   task automatic test_reset();
      reset = 1'b1; i_ready = 1'b0; num_1 = '0; num_2 = '0; op_code = '0;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({result, flag_zero, flag_carry, flag_err, busy, overrun, o_ready} !== 22'd0) begin
         errors++;
         $display("FAIL reset_state: got %h expected 0",
                  {result, flag_zero, flag_carry, flag_err, busy, overrun, o_ready});
      end
      reset = 1'b1;
   endtask

   // a, b, op, expected result, carry, err, latency
   int va[13]  = '{8'hF0, 8'h05, 8'h5A, 8'hFF, 200, 200, 9, 8'h33, 8'hFF, 8'h80, 8'hF0, 8'hF0, 8'h12};
   int vb[13]  = '{8'h20, 8'h07, 8'h5A, 8'hFF, 7,   7,   0, 8'h44, 8'h0F, 8'h03, 8'h3C, 8'h0F, 8'h00};
   int vop[13] = '{0,     1,     4,     5,     6,   7,   6, 8'h0A, 8,     9,     2,     3,     5};
   int vr[13]  = '{16'h0110, 16'h00FE, 0, 16'hFE01, 16'h1C, 4, 0, 0, 16'h7F80, 16'h10, 16'h30, 16'hFF, 0};
   bit vc[13]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   bit ve[13]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
   int vl[13]  = '{1, 1, 1, 8, 8, 8, 1, 1, 1, 1, 1, 1, 1};

   task automatic test_vectors();
      logic [15:0] r, er;
      logic z, c, e;
      int lat, bcnt;
      for (int i = 0; i < 13; i++) begin
         do_op(8'(va[i]), 8'(vb[i]), 8'(vop[i]), r, z, c, e, lat, bcnt);
         er = 16'(vr[i]);
         checks++;
         if ({r, z, c, e} !== {er, er == 16'd0, vc[i], ve[i]}) begin
            errors++;
            $display("FAIL vector%0d_result: got r=%h z=%b c=%b e=%b expected r=%h z=%b c=%b e=%b",
                     i, r, z, c, e, er, er == 16'd0, vc[i], ve[i]);
         end
         checks++;
         if (lat !== vl[i] || bcnt !== vl[i]) begin
            errors++;
            $display("FAIL vector%0d_latency: got lat=%0d busy_cycles=%0d expected %0d", i, lat, bcnt, vl[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      num_1 = 8'h10; num_2 = 8'h20; op_code = 8'h01; i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      n = 0;
      while (!o_ready && n < 40) begin @(negedge clk); n++; end
      num_1 = 8'hC3; num_2 = 8'h5E; op_code = 8'h02; i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      checks++;
      if ({busy, o_ready, overrun, result} !== {1'b1, 1'b0, 1'b0, 16'h00F0}) begin
         errors++;
         $display("FAIL b2b_accept: got busy=%b o_ready=%b overrun=%b r=%h expected 1 0 0 00f0",
                  busy, o_ready, overrun, result);
      end
      @(negedge clk);
      checks++;
      if ({o_ready, result, flag_carry} !== {1'b1, 16'h0042, 1'b0}) begin
         errors++;
         $display("FAIL b2b_result: got o_ready=%b r=%h c=%b expected 1 0042 0", o_ready, result, flag_carry);
      end
      @(negedge clk);
      checks++;
      if ({o_ready, result} !== {1'b0, 16'h0042}) begin
         errors++;
         $display("FAIL b2b_hold: got o_ready=%b r=%h expected 0 0042", o_ready, result);
      end
   endtask

   task automatic test_random();
      logic [7:0] a, b, op;
      logic [15:0] r;
      logic z, c, e;
      int lat, bcnt, er, el;
      bit ec, ee;
      for (int i = 0; i < 40; i++) begin
         a  = 8'($urandom);
         b  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
         op = 8'($urandom_range(0, 11));
         model(int'(a), int'(b), int'(op), er, ec, ee, el);
         do_op(a, b, op, r, z, c, e, lat, bcnt);
         checks++;
         if ({r, z, c, e} !== {16'(er), er == 0, ec, ee}) begin
            errors++;
            $display("FAIL random_op%0h(%h,%h): got r=%h z=%b c=%b e=%b expected r=%h z=%b c=%b e=%b",
                     op, a, b, r, z, c, e, 16'(er), er == 0, ec, ee);
         end
         checks++;
         if (lat !== el) begin
            errors++;
            $display("FAIL random_latency_op%0h: got %0d expected %0d", op, lat, el);
         end
      end
   endtask

   task automatic test_overrun();
      logic [15:0] r;
      logic z, c, e;
      int n, bcnt;
      @(negedge clk);
      num_1 = 8'hB7; num_2 = 8'h6D; op_code = 8'h05; i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      repeat (2) @(negedge clk);
      num_1 = 8'h01; num_2 = 8'h01; op_code = 8'h00; i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      checks++;
      if ({overrun, busy} !== 2'b11) begin
         errors++;
         $display("FAIL overrun_set: got overrun=%b busy=%b expected 1 1", overrun, busy);
      end
      n = 3;
      while (!o_ready && n < 40) begin @(negedge clk); n++; end
      checks++;
      if ({n, result, flag_err} !== {32'd8, 16'(32'hB7 * 32'h6D), 1'b0}) begin
         errors++;
         $display("FAIL overrun_mul: got lat=%0d r=%h e=%b expected 8 %h 0", n, result, flag_err, 16'(32'hB7 * 32'h6D));
      end
      do_op(8'h3C, 8'h11, 8'h0A, r, z, c, e, n, bcnt);
      checks++;
      if ({r, z, c, e, overrun} !== {16'h0000, 1'b1, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL illegal_op: got r=%h z=%b c=%b e=%b overrun=%b expected 0000 1 0 1 1", r, z, c, e, overrun);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      logic z, c, e;
      int lat, bcnt, pulses;
      @(negedge clk);
      num_1 = 8'd200; num_2 = 8'd7; op_code = 8'h06; i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({result, flag_zero, flag_carry, flag_err, busy, overrun, o_ready} !== 22'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h expected 0",
                  {result, flag_zero, flag_carry, flag_err, busy, overrun, o_ready});
      end
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (o_ready) pulses++;
         if (k == 2) reset = 1'b1;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL reset_mid_no_ready: got %0d o_ready pulses expected 0", pulses);
      end
      do_op(8'h01, 8'h01, 8'h00, r, z, c, e, lat, bcnt);
      checks++;
      if ({r, z, c, e, overrun, lat} !== {16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1}) begin
         errors++;
         $display("FAIL reset_mid_recover: got r=%h z=%b c=%b e=%b overrun=%b lat=%0d expected 0002 0 0 0 0 1",
                  r, z, c, e, overrun, lat);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_random();
      test_overrun();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
